// File: rtl/cpu_bus_rmw.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_rmw
// Purpose  : Core-to-word-bus adapter. Byte reads use lane extraction, byte
//            writes use read-modify-write. Optional BUS_TIMEOUT_EN aborts
//            stalled bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_rmw #(
    parameter int AW         = 24,
    parameter int NIRQ       = 16,
    parameter int IRQ_SYNC   = 2,
    parameter int TMO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_stb,
    input  logic            cpu_we,
    input  logic            cpu_ben,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [31:0]     cpu_dout,
    output logic [31:0]     cpu_din,
    output logic            cpu_ack,
    output logic [NIRQ-1:0] cpu_irq,
    output logic            bus_stb,
    output logic            bus_we,
    output logic [AW-3:0]   bus_addr,
    output logic [31:0]     bus_dout,
    input  logic [31:0]     bus_din,
    input  logic            bus_ack,
    input  logic [NIRQ-1:0] bus_irq,
    output logic            bus_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WORD    = 3'd1,
        RMW_RD  = 3'd2,
        RMW_GAP = 3'd3,
        RMW_WR  = 3'd4,
        DONE    = 3'd5
    } state_t;

    generate
        if (IRQ_SYNC < 1 || IRQ_SYNC > 4 || TMO_CYCLES < 1) begin : g_param_check
            $error("cpu_bus_rmw: IRQ_SYNC must be 1..4 and TMO_CYCLES >= 1");
        end
    endgenerate

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            ben_q, ben_d;
    logic [1:0]      off_q, off_d;
    logic [7:0]      wbyte_q, wbyte_d;
    logic [31:0]     merge_q, merge_d;
    logic [31:0]     cpu_din_q, cpu_din_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic            bus_stb_q, bus_stb_d;
    logic            bus_we_q, bus_we_d;
    logic [AW-3:0]   bus_addr_q, bus_addr_d;
    logic [31:0]     bus_dout_q, bus_dout_d;
    logic [NIRQ-1:0] irq_sync_q [IRQ_SYNC];
    logic [NIRQ-1:0] irq_sync_d [IRQ_SYNC];

    logic            w_ack;
    logic [7:0]      w_lane;
    logic [31:0]     w_merged;

`ifdef BUS_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TMO_CYCLES + 1);
    logic [C_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic               abort_q, abort_d;
    logic               bus_err_q, bus_err_d;
    logic               w_tmo;

    // An ack on the terminal cycle wins over the abort.
    assign w_tmo = bus_stb_q & ~bus_ack & (tmo_cnt_q == C_TMO_W'(TMO_CYCLES - 1));
`endif

    assign w_ack = bus_ack & bus_stb_q;

    always_comb begin
        w_lane   = bus_din[{off_q, 3'b000} +: 8];
        w_merged = bus_din;
        w_merged[{off_q, 3'b000} +: 8] = wbyte_q;
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        ben_d      = ben_q;
        off_d      = off_q;
        wbyte_d    = wbyte_q;
        merge_d    = merge_q;
        cpu_din_d  = cpu_din_q;
        cpu_ack_d  = 1'b0;
        bus_stb_d  = bus_stb_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_dout_d = bus_dout_q;

        irq_sync_d[0] = bus_irq;
        for (int i = 1; i < IRQ_SYNC; i++) begin
            irq_sync_d[i] = irq_sync_q[i-1];
        end

        case (state_q)
            IDLE: begin
                // A still-high strobe during the ack cycle belongs to the finished request.
                if (cpu_stb && !cpu_ack_q) begin
                    we_d       = cpu_we;
                    ben_d      = cpu_ben;
                    off_d      = cpu_addr[1:0];
                    wbyte_d    = cpu_dout[7:0];
                    bus_addr_d = cpu_addr[AW-1:2];
                    bus_stb_d  = 1'b1;
                    bus_we_d   = cpu_we & ~cpu_ben;
                    if (cpu_we && !cpu_ben) begin
                        bus_dout_d = cpu_dout;
                    end
                    state_d = (cpu_we && cpu_ben) ? RMW_RD : WORD;
                end
            end
            WORD: begin
                if (w_ack) begin
                    bus_stb_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = DONE;
                    if (!we_q) begin
                        cpu_din_d = ben_q ? {24'b0, w_lane} : bus_din;
                    end
                end
            end
            RMW_RD: begin
                if (w_ack) begin
                    merge_d   = w_merged;
                    bus_stb_d = 1'b0;
                    state_d   = RMW_GAP;
                end
            end
            RMW_GAP: begin
                bus_stb_d  = 1'b1;
                bus_we_d   = 1'b1;
                bus_dout_d = merge_q;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                if (w_ack) begin
                    bus_stb_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                cpu_ack_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef BUS_TIMEOUT_EN
        abort_d   = abort_q;
        bus_err_d = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        if (bus_stb_d && !bus_stb_q) begin
            tmo_cnt_d = '0;
        end else if (bus_stb_q && !bus_ack) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (state_q == DONE) begin
            bus_err_d = abort_q;
            abort_d   = 1'b0;
        end
        // Abort from any strobed state; from RMW_RD this skips the write phase.
        if (w_tmo) begin
            bus_stb_d = 1'b0;
            bus_we_d  = 1'b0;
            cpu_din_d = 32'h0;
            abort_d   = 1'b1;
            state_d   = DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            ben_q      <= 1'b0;
            off_q      <= 2'b00;
            wbyte_q    <= 8'h00;
            merge_q    <= 32'h0;
            cpu_din_q  <= 32'h0;
            cpu_ack_q  <= 1'b0;
            bus_stb_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_dout_q <= 32'h0;
            for (int i = 0; i < IRQ_SYNC; i++) begin
                irq_sync_q[i] <= '0;
            end
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            abort_q    <= 1'b0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            ben_q      <= ben_d;
            off_q      <= off_d;
            wbyte_q    <= wbyte_d;
            merge_q    <= merge_d;
            cpu_din_q  <= cpu_din_d;
            cpu_ack_q  <= cpu_ack_d;
            bus_stb_q  <= bus_stb_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_dout_q <= bus_dout_d;
            for (int i = 0; i < IRQ_SYNC; i++) begin
                irq_sync_q[i] <= irq_sync_d[i];
            end
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            abort_q    <= abort_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign cpu_din  = cpu_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign cpu_irq  = irq_sync_q[IRQ_SYNC-1];
    assign bus_stb  = bus_stb_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_dout = bus_dout_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_err  = bus_err_q;
`else
    assign bus_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/cpu_bus_rmw.md
Name: cpu_bus_rmw

Overview:
- Parametrised successor to the RISC5 core-to-bus adapter; sits between cpu_core and the system word bus.
- Converts the core's byte-addressed request (word or byte, read or write) into word-only bus cycles.
- Byte reads use lane extraction. Byte writes use an internal read-modify-write sequence.
- Interrupt requests are synchronised through a configurable-depth register chain.

Parameters:
AW, 24, core byte-address width; bus word address is AW-2 bits
NIRQ, 16, number of interrupt request lines
IRQ_SYNC, 2, synchroniser stages on bus_irq (legal 1..4)
TMO_CYCLES, 255, bus-wait cycles before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
cpu_stb  in  1  core request strobe, held until cpu_ack
cpu_we  in  1  core write enable
cpu_ben  in  1  byte access (1) / word access (0)
cpu_addr  in  AW  core byte address
cpu_dout  in  32  core write data; byte data in [7:0]
cpu_din  out  32  read data to core, registered
cpu_ack  out  1  one-cycle completion pulse
cpu_irq  out  NIRQ  synchronised interrupt requests
bus_stb  out  1  bus strobe, registered
bus_we  out  1  bus write enable, registered
bus_addr  out  AW-2  bus word address, cpu_addr[AW-1:2]
bus_dout  out  32  bus write data, registered
bus_din  in  32  bus read data, valid with bus_ack
bus_ack  in  1  bus acknowledge
bus_irq  in  NIRQ  raw interrupt requests
bus_err  out  1  one-cycle timeout pulse; constant 0 without BUS_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE.
  - Reset value 0: cpu_din, cpu_ack, cpu_irq, bus_stb, bus_we, bus_addr, bus_dout, bus_err, all synchroniser flops.
- FSM states: IDLE, WORD, RMW_RD, RMW_GAP, RMW_WR, DONE.
- IDLE:
  - cpu_stb=1 latches cpu_we, cpu_ben, cpu_addr, cpu_dout.
  - Next state is RMW_RD if cpu_ben&cpu_we, else WORD.
  - bus_stb=1 from the following cycle.
  - bus_we=1 only for word writes; bus_dout=cpu_dout for word writes.
- WORD:
  - Holds bus_stb until bus_ack=1, then goes to DONE and bus_stb=0.
  - Word read: cpu_din<=bus_din.
  - Byte read: cpu_din<={24'b0, lane}, where lane is selected by addr[1:0], little-endian (0 -> [7:0], 3 -> [31:24]).
- RMW_RD:
  - bus read at same address; on bus_ack, merged word <= bus_din with selected lane replaced by cpu_dout[7:0].
  - Goes to RMW_GAP with bus_stb=0.
- RMW_GAP: one idle bus cycle, then bus_stb=1, bus_we=1, bus_dout=merged word. Goes to RMW_WR.
- RMW_WR: on bus_ack goes to DONE with bus_stb=0.
- DONE: cpu_ack=1 for exactly one cycle, then IDLE.
- Latency (bus acks in its first strobed cycle):
  - Word access: cpu_stb sampled at edge 0; cpu_ack high in cycle 3.
  - Byte write: cpu_ack high in cycle 5.
- Core handshake:
  - Core drops cpu_stb, or presents a new request, in the cycle after cpu_ack.
  - IDLE samples cpu_stb only when cpu_ack=0.
  - Changes on cpu_* after acceptance are ignored until DONE.
- bus_stb is low for at least one cycle between any two bus transactions.
- bus_ack while bus_stb=0 is ignored.
- Reset mid-transaction: immediate return to IDLE. No cpu_ack is issued; a partial RMW never writes.
- IRQ: cpu_irq = bus_irq delayed by exactly IRQ_SYNC clocks, per line, no edge detection.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - A counter of width clog2(TMO_CYCLES+1) clears on each bus_stb rising edge and counts cycles with bus_stb=1 & bus_ack=0.
  - At count TMO_CYCLES the transaction aborts: bus_stb=0, cpu_din=0, next state DONE; bus_err=1 in the same cycle as cpu_ack.
  - An abort in RMW_RD skips the write phase.
  - bus_ack in the same cycle as the terminal count is a normal completion; no error is raised.
- Without the macro: no counter, the FSM waits indefinitely, bus_err tied 0.

Test Plan:
- Word read, addr 0x000104, bus_din=0xDEADBEEF acked on first strobe cycle -> bus_addr=0x41, bus_we=0, cpu_din=0xDEADBEEF, cpu_ack in cycle 3.
- Byte read, addr 0x000102, bus_din=0x11223344 -> cpu_din=0x00000022; repeat with addr[1:0]=3 -> 0x00000011.
- Byte write, addr 0x000201, cpu_dout=0xAB, bus read returns 0x11223344 -> exactly one bus_stb-low gap cycle, then write of 0x1122AB44 to bus_addr 0x80; single cpu_ack in cycle 5.
- rst pulsed low during RMW_GAP -> all outputs 0 immediately, no write strobe, no cpu_ack; next request served normally.
- bus_irq[5] rises with IRQ_SYNC=2 -> cpu_irq[5] rises exactly 2 clocks later, other lines unchanged.
- BUS_TIMEOUT_EN, TMO_CYCLES=8, bus never acks -> after 8 strobed cycles bus_stb=0, cpu_din=0, cpu_ack and bus_err both high one cycle; ack at cycle 8 -> no bus_err.
